// File: rtl/for_window_acc.sv
// for_window_acc: sums every WINDOW accepted beats into a one-entry output register.
// Define FOR_WINDOW_ACC_MAX_EN to also report the per-window maximum on OUT_MAX.
module for_window_acc #(
    parameter int NBITS  = 8,
    parameter int WINDOW = 4,
    parameter int ACCW   = NBITS + $clog2(WINDOW)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NBITS-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             CLEAR,
    output logic [ACCW-1:0]  OUT_SUM,
    output logic [NBITS-1:0] OUT_MAX,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CW = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t          state;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_next;
    logic [ACCW-1:0] sum_r;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            accept;

    assign last      = (cnt == LAST);
    assign OUT_VALID = (state == FULL);
    assign OUT_SUM   = sum_r;
    assign acc_next  = acc + ACCW'(IN_DATA);

    // Stall only when the closing beat would overwrite an unconsumed result.
    assign IN_READY = !CLEAR && !(last && OUT_VALID && !OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc <= '0;
            cnt <= '0;
        end else if (CLEAR) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= EMPTY;
            sum_r <= '0;
        end else if (accept && last) begin
            state <= FULL;
            sum_r <= acc_next;
        end else if (state == FULL && OUT_READY) begin
            state <= EMPTY;
        end
    end

`ifdef FOR_WINDOW_ACC_MAX_EN
    logic [NBITS-1:0] max_r;
    logic [NBITS-1:0] max_next;
    logic [NBITS-1:0] max_out;

    assign max_next = (IN_DATA > max_r) ? IN_DATA : max_r;
    assign OUT_MAX  = max_out;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            max_r <= '0;
        end else if (CLEAR) begin
            max_r <= '0;
        end else if (accept) begin
            max_r <= last ? '0 : max_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            max_out <= '0;
        end else if (accept && last) begin
            max_out <= max_next;
        end
    end
`else
    assign OUT_MAX = '0;
`endif

endmodule

// File: tb/tb_for_window_acc.sv
// Directed bench for for_window_acc (NBITS=8, WINDOW=4).
// Expected OUT_MAX values depend on FOR_WINDOW_ACC_MAX_EN.
module tb_for_window_acc;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] IN_DATA = '0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic       CLEAR = 1'b0;
    logic [9:0] OUT_SUM;
    logic [7:0] OUT_MAX;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FOR_WINDOW_ACC_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    for_window_acc #(.NBITS(8), .WINDOW(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .CLEAR    (CLEAR),
        .OUT_SUM  (OUT_SUM),
        .OUT_MAX  (OUT_MAX),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_max;
        exp_max = 8'd0;
        RST_N = 1'b0;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid got %0b want 0", OUT_VALID);
        end
        n_cmp++;
        if (OUT_SUM !== 10'd0) begin
            n_err++;
            $display("FAIL reset_sum got %0d want 0", OUT_SUM);
        end
        n_cmp++;
        if (OUT_MAX !== exp_max) begin
            n_err++;
            $display("FAIL reset_max got %0d want 0", OUT_MAX);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        n_cmp++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got %0b want 1", IN_READY);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_max;
        exp_max = MAX_EN ? 8'd20 : 8'd0;
        OUT_READY = 1'b1;
        beat(8'd5);
        beat(8'd10);
        beat(8'd15);
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_valid got %0b want 0", OUT_VALID);
        end
        beat(8'd20);
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd50) begin
            n_err++;
            $display("FAIL basic_sum got v=%0b %0d want v=1 50", OUT_VALID, OUT_SUM);
        end
        n_cmp++;
        if (OUT_MAX !== exp_max) begin
            n_err++;
            $display("FAIL basic_max got %0d want %0d", OUT_MAX, exp_max);
        end
        tick();
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL basic_one_cycle got %0b want 0", OUT_VALID);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_max;
        exp_max = MAX_EN ? 8'd255 : 8'd0;
        OUT_READY = 1'b1;
        repeat (4) beat(8'd255);
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd1020) begin
            n_err++;
            $display("FAIL ovf_sum got v=%0b %0d want v=1 1020", OUT_VALID, OUT_SUM);
        end
        n_cmp++;
        if (OUT_MAX !== exp_max) begin
            n_err++;
            $display("FAIL ovf_max got %0d want %0d", OUT_MAX, exp_max);
        end
        tick();
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        beat(8'd5);
        beat(8'd10);
        beat(8'd15);
        beat(8'd20);
        beat(8'd1);
        beat(8'd2);
        beat(8'd3);
        IN_VALID = 1'b1;
        IN_DATA  = 8'd4;
        #1;
        n_cmp++;
        if (IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stall got %0b want 0", IN_READY);
        end
        tick();
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd50) begin
            n_err++;
            $display("FAIL bp_hold got v=%0b %0d want v=1 50", OUT_VALID, OUT_SUM);
        end
        OUT_READY = 1'b1;
        #1;
        n_cmp++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got %0b want 1", IN_READY);
        end
        tick();
        IN_VALID = 1'b0;
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd10) begin
            n_err++;
            $display("FAIL bp_next got v=%0b %0d want v=1 10", OUT_VALID, OUT_SUM);
        end
        tick();
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain got %0b want 0", OUT_VALID);
        end
    endtask

    task automatic test_back_to_back();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 8'(i);
            n_cmp++;
            if (IN_READY !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready beat %0d got %0b want 1", i, IN_READY);
            end
            tick();
            if (i == 4) begin
                n_cmp++;
                if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd10) begin
                    n_err++;
                    $display("FAIL b2b_w1 got v=%0b %0d want v=1 10", OUT_VALID, OUT_SUM);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (OUT_VALID !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_gap got %0b want 0", OUT_VALID);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd26) begin
                    n_err++;
                    $display("FAIL b2b_w2 got v=%0b %0d want v=1 26", OUT_VALID, OUT_SUM);
                end
            end
        end
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        logic [7:0] exp_max;
        exp_max = MAX_EN ? 8'd1 : 8'd0;
        OUT_READY = 1'b1;
        beat(8'd7);
        beat(8'd7);
        CLEAR    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'd9;
        #1;
        n_cmp++;
        if (IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready got %0b want 0", IN_READY);
        end
        tick();
        CLEAR    = 1'b0;
        IN_VALID = 1'b0;
        repeat (4) beat(8'd1);
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd4) begin
            n_err++;
            $display("FAIL clr_sum got v=%0b %0d want v=1 4", OUT_VALID, OUT_SUM);
        end
        n_cmp++;
        if (OUT_MAX !== exp_max) begin
            n_err++;
            $display("FAIL clr_max got %0d want %0d", OUT_MAX, exp_max);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_max;
        exp_max = MAX_EN ? 8'd2 : 8'd0;
        OUT_READY = 1'b0;
        beat(8'd1);
        beat(8'd2);
        beat(8'd3);
        beat(8'd4);
        beat(8'd3);
        beat(8'd3);
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd10) begin
            n_err++;
            $display("FAIL arst_pre got v=%0b %0d want v=1 10", OUT_VALID, OUT_SUM);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if (OUT_VALID !== 1'b0 || OUT_SUM !== 10'd0 || OUT_MAX !== 8'd0) begin
            n_err++;
            $display("FAIL arst_now got v=%0b s=%0d m=%0d want 0 0 0",
                     OUT_VALID, OUT_SUM, OUT_MAX);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        tick();
        repeat (4) beat(8'd2);
        n_cmp++;
        if (OUT_VALID !== 1'b1 || OUT_SUM !== 10'd8) begin
            n_err++;
            $display("FAIL arst_post got v=%0b %0d want v=1 8", OUT_VALID, OUT_SUM);
        end
        n_cmp++;
        if (OUT_MAX !== exp_max) begin
            n_err++;
            $display("FAIL arst_max got %0d want %0d", OUT_MAX, exp_max);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
